btn_event_ctrl: RTL and testbench
=================================

// Module: btn_event_ctrl
// PURPOSE
//  Consumes the clean, registered level from the button debouncer and turns it into discrete UI events.
//  Events: press, release, long-press, auto-repeat, plus a wrapping press count.
//  Sits between the debouncer output and the core/control logic, e.g. single-step and run/halt buttons.
// PARAMETERS
//  ACTIVE_LEVEL  1'b1        i_btn level that means "pressed"; must match the debouncer's ~DEFAULT_D
//  LONG_CNT      30_000_000  cycles held after o_press before o_long (1 s @ 30 MHz); >=1, < 2**CNT_W
//  REPEAT_CNT    6_000_000   cycles between o_repeat pulses after o_long (200 ms); >=1, < 2**CNT_W
//  REPEAT_EN     1'b1        1: auto-repeat enabled; 0: o_repeat held 0
//  CNT_W         25          hold-counter width
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-low
//  i_btn        in   1  debounced button level, already synchronous to clk
//  o_press      out  1  1-cycle pulse on press
//  o_release    out  1  1-cycle pulse on release
//  o_long       out  1  1-cycle pulse when held LONG_CNT cycles
//  o_repeat     out  1  1-cycle pulse every REPEAT_CNT cycles after o_long
//  o_held       out  1  level; 1 while FSM is not IDLE
//  o_press_cnt  out  8  number of presses, mod 256
// BEHAVIOUR
//  - Reset: rst=0 asynchronously forces state=IDLE, cnt=0, all outputs 0, regardless of i_btn.
//    This also applies mid-hold; no o_release is emitted for a hold aborted by reset.
//  - All outputs are registered. Pulse outputs default to 0 every cycle unless set below.
//  - Let act = (i_btn==ACTIVE_LEVEL), sampled at each posedge clk.
//  - FSM states: IDLE, PRESS, HOLD.
//  - IDLE:
//      act=1 -> PRESS, cnt<=0, o_press<=1, o_press_cnt<=o_press_cnt+1 (255 wraps to 0).
//      act=0 -> stay.
//      Note: i_btn already active at reset release counts as a press on the first edge.
//  - PRESS:
//      act=0                  -> IDLE, cnt<=0, o_release<=1.
//      else cnt==LONG_CNT-1   -> HOLD, cnt<=0, o_long<=1.
//      else                   -> cnt<=cnt+1.
//  - HOLD:
//      act=0                           -> IDLE, cnt<=0, o_release<=1.
//      else cnt==REPEAT_CNT-1          -> cnt<=0, o_repeat<=REPEAT_EN.
//      else                            -> cnt<=cnt+1.
//  - Latency:
//      o_press is high in the cycle after the first sampled act=1.
//      o_long rises exactly LONG_CNT cycles after o_press.
//      Each o_repeat follows the previous o_long/o_repeat by exactly REPEAT_CNT cycles.
//  - Simultaneous events: release on the same edge as a count threshold -> release wins.
//    No o_long or o_repeat is emitted in that case.
//  - At most one pulse output is high in any cycle. o_held = (state!=IDLE), registered with the state.
//  - Counter never exceeds its threshold; cnt stays 0 in IDLE.
// TESTING  (LONG_CNT=8, REPEAT_CNT=4, REPEAT_EN=1 unless noted)
//  1. Short press: i_btn=1 for 3 cycles, then 0.
//     -> one o_press, one o_release 3 cycles after it, no o_long, o_press_cnt=1.
//  2. Long hold: i_btn=1 for 20 cycles.
//     -> o_long 8 cycles after o_press; o_repeat 4 and 8 cycles after o_long; o_held=1 throughout.
//  3. Boundary: release sampled on the edge where cnt==7 in PRESS.
//     -> o_release only, no o_long; FSM back in IDLE.
//  4. REPEAT_EN=0 with a 30-cycle hold -> o_long once, o_repeat never asserted.
//  5. Wrap: 256 short presses -> o_press_cnt returns to 0; each press gives exactly one o_press.
//  6. Reset mid-HOLD: drive rst=0 with i_btn=1.
//     -> all outputs 0 immediately; on rst=1 with i_btn=1, o_press on the first edge.

Source files
------------

// File: rtl/btn_event_ctrl_if.sv
// rtl/btn_event_ctrl_if.sv - button level in, UI event pulses and press count out
interface btn_event_ctrl_if;
    logic       i_btn;
    logic       o_press;
    logic       o_release;
    logic       o_long;
    logic       o_repeat;
    logic       o_held;
    logic [7:0] o_press_cnt;

    modport master (
        output i_btn,
        input  o_press, o_release, o_long, o_repeat, o_held, o_press_cnt
    );

    modport slave (
        input  i_btn,
        output o_press, o_release, o_long, o_repeat, o_held, o_press_cnt
    );
endinterface

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - turns a debounced button level into press/release/long/repeat events
module btn_event_ctrl #(
    parameter logic        ACTIVE_LEVEL = 1'b1,
    parameter int unsigned LONG_CNT     = 30_000_000,
    parameter int unsigned REPEAT_CNT   = 6_000_000,
    parameter logic        REPEAT_EN    = 1'b1,
    parameter int unsigned CNT_W        = 25
) (
    input  logic                clk,
    input  logic                rst,
    btn_event_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       press_cnt, press_cnt_nxt;
    logic             press_q, release_q, long_q, repeat_q, held_q;
    logic             press_nxt, release_nxt, long_nxt, repeat_nxt;
    logic             act;

    assign act = (bus.i_btn == ACTIVE_LEVEL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            press_cnt <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            press_cnt <= press_cnt_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            long_q    <= long_nxt;
            repeat_q  <= repeat_nxt;
            held_q    <= (state_nxt != IDLE);
        end
    end

    // Release is tested before the thresholds so it wins on a coincident edge.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        press_cnt_nxt = press_cnt;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;
        repeat_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (act) begin
                    state_nxt     = PRESS;
                    press_nxt     = 1'b1;
                    press_cnt_nxt = press_cnt + 8'd1;
                end
            end
            PRESS: begin
                if (!act) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!act) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_nxt    = '0;
                    repeat_nxt = REPEAT_EN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.o_press     = press_q;
    assign bus.o_release   = release_q;
    assign bus.o_long      = long_q;
    assign bus.o_repeat    = repeat_q;
    assign bus.o_held      = held_q;
    assign bus.o_press_cnt = press_cnt;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - bench for btn_event_ctrl against an event-age reference model
module tb_btn_event_ctrl;
    localparam int LONG   = 8;
    localparam int REPEAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference state: whether a press is in progress and how many edges since its o_press.
    bit   m_pressed;
    int   m_age;
    int   m_count;
    bit   e_press, e_release, e_long, e_repeat;

    btn_event_ctrl_if bus0 ();
    btn_event_ctrl_if bus1 ();
    assign bus0.i_btn = btn;
    assign bus1.i_btn = btn;

    btn_event_ctrl #(.ACTIVE_LEVEL(1'b1), .LONG_CNT(LONG), .REPEAT_CNT(REPEAT),
                     .REPEAT_EN(1'b1), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    btn_event_ctrl #(.ACTIVE_LEVEL(1'b1), .LONG_CNT(LONG), .REPEAT_CNT(REPEAT),
                     .REPEAT_EN(1'b0), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        logic press, rel, lng, rpt, held;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pressed = 0; m_age = 0; m_count = 0;
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
    endtask

    task automatic model_edge(input bit act);
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
        if (!m_pressed) begin
            if (act) begin
                e_press = 1; m_pressed = 1; m_age = 0; m_count = (m_count + 1) % 256;
            end
        end else if (!act) begin
            e_release = 1; m_pressed = 0;
        end else begin
            m_age++;
            if (m_age == LONG) e_long = 1;
            else if (m_age > LONG && (m_age - LONG) % REPEAT == 0) e_repeat = 1;
        end
    endtask

    task automatic compare_all();
        check("dut0 press",   int'(bus0.o_press),     int'(e_press));
        check("dut0 release", int'(bus0.o_release),   int'(e_release));
        check("dut0 long",    int'(bus0.o_long),      int'(e_long));
        check("dut0 repeat",  int'(bus0.o_repeat),    int'(e_repeat));
        check("dut0 held",    int'(bus0.o_held),      int'(m_pressed));
        check("dut0 cnt",     int'(bus0.o_press_cnt), m_count);
        check("dut1 press",   int'(bus1.o_press),     int'(e_press));
        check("dut1 release", int'(bus1.o_release),   int'(e_release));
        check("dut1 long",    int'(bus1.o_long),      int'(e_long));
        check("dut1 repeat",  int'(bus1.o_repeat),    0);
        check("dut1 held",    int'(bus1.o_held),      int'(m_pressed));
        check("dut1 cnt",     int'(bus1.o_press_cnt), m_count);
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        btn = b;
        @(posedge clk);
        model_edge(b);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " press"},   int'(bus0.o_press),     0);
        check({tag, " release"}, int'(bus0.o_release),   0);
        check({tag, " long"},    int'(bus0.o_long),      0);
        check({tag, " repeat"},  int'(bus0.o_repeat),    0);
        check({tag, " held"},    int'(bus0.o_held),      0);
        check({tag, " cnt"},     int'(bus0.o_press_cnt), 0);
        check({tag, " dut1 held"}, int'(bus1.o_held),    0);
        check({tag, " dut1 cnt"},  int'(bus1.o_press_cnt), 0);
    endtask

    initial begin
        int press_at, long_at, n_long, n_rep0, n_rep1, n_press, run;
        int rep_at[$];
        logic lvl;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with the button active: nothing may leak out.
        model_reset();
        btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        btn = 1'b0;
        rst = 1'b1;

        // Short press from the table.
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].btn);
            check($sformatf("tbl%0d press", i),   int'(bus0.o_press),   int'(vecs[i].press));
            check($sformatf("tbl%0d release", i), int'(bus0.o_release), int'(vecs[i].rel));
            check($sformatf("tbl%0d long", i),    int'(bus0.o_long),    int'(vecs[i].lng));
            check($sformatf("tbl%0d repeat", i),  int'(bus0.o_repeat),  int'(vecs[i].rpt));
            check($sformatf("tbl%0d held", i),    int'(bus0.o_held),    int'(vecs[i].held));
        end
        check("short press count", int'(bus0.o_press_cnt), 1);

        // Long hold of 20 cycles: long 8 after press, repeats 4 and 8 after long.
        press_at = -1; long_at = -1; n_long = 0;
        rep_at.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            if (bus0.o_press) press_at = i;
            if (bus0.o_long) begin long_at = i; n_long++; end
            if (bus0.o_repeat) rep_at.push_back(i);
            check("hold held", int'(bus0.o_held), 1);
        end
        check("hold long count", n_long, 1);
        check("hold long latency", long_at - press_at, LONG);
        check("hold repeat count", rep_at.size(), 2);
        if (rep_at.size() == 2) begin
            check("hold repeat1 latency", rep_at[0] - long_at, REPEAT);
            check("hold repeat2 latency", rep_at[1] - long_at, 2 * REPEAT);
        end
        step(1'b0);
        check("hold release", int'(bus0.o_release), 1);
        step(1'b0);

        // Release on the edge where the long threshold would fire.
        for (int i = 0; i < LONG; i++) step(1'b1);
        step(1'b0);
        check("boundary release", int'(bus0.o_release), 1);
        check("boundary no long", int'(bus0.o_long), 0);
        check("boundary idle", int'(bus0.o_held), 0);
        step(1'b0);
        check("boundary still no long", int'(bus0.o_long), 0);

        // 30-cycle hold against the repeat-disabled instance.
        n_long = 0; n_rep0 = 0; n_rep1 = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1);
            n_long += int'(bus1.o_long);
            n_rep1 += int'(bus1.o_repeat);
            n_rep0 += int'(bus0.o_repeat);
        end
        check("norep long count", n_long, 1);
        check("norep repeat count", n_rep1, 0);
        check("rep repeat count", n_rep0, (30 - 1 - LONG) / REPEAT);
        step(1'b0);

        // 256 short presses wrap the counter back to where it started.
        run = int'(bus0.o_press_cnt);
        n_press = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1);
            n_press += int'(bus0.o_press);
            step(1'b0);
            n_press += int'(bus0.o_press);
        end
        check("wrap press pulses", n_press, 256);
        check("wrap count", int'(bus0.o_press_cnt), run);

        // Randomized level runs against the model.
        lvl = 1'b0;
        for (int r = 0; r < 150; r++) begin
            lvl = ~lvl;
            run = $urandom_range(1, 20);
            for (int i = 0; i < run; i++) step(lvl);
        end

        // Asynchronous reset in the middle of a hold.
        for (int i = 0; i < LONG + 3; i++) step(1'b1);
        check("pre-reset held", int'(bus0.o_held), 1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        rst = 1'b1;
        step(1'b1);
        check("post-reset press", int'(bus0.o_press), 1);
        check("post-reset count", int'(bus0.o_press_cnt), 1);
        step(1'b0);
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
